imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_pkg.sv | 25 ++
 rtl/imem_responder_if.sv | 34 +++
 rtl/imem_array.sv | 32 +++
 rtl/imem_responder.sv | 166 ++++++++++++++++
 tb/tb_imem_responder.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory responder:
//   state_t     - responder FSM states (IDLE / WAIT / RESP)
//   NOP_INSTR   - RV32 "addi x0,x0,0", returned after reset and on faults
//   word_offset - byte address to word offset relative to a base address
// ---------------------------------------------------------------------------
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Word offset of byte_addr from base_addr; callers truncate to their depth,
  // which gives the modulo-depth wrap for free.
  function automatic logic [31:0] word_offset(input logic [31:0] byte_addr,
                                              input logic [31:0] base_addr);
    word_offset = (byte_addr - base_addr) >> 2;
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// ---------------------------------------------------------------------------
// imem_responder_if
// Fetch-side bus of the instruction memory responder.
//   REQ/ADDR          fetch request strobe and byte address (master -> slave)
//   READY             slave can accept a request this cycle
//   RDATA/VALID       returned instruction word and its one-cycle strobe
//   WE/WADDR/WDATA    preload write port (byte address, word data)
//   ERR               response fault flag, only with IMEM_ADDR_CHECK_EN
// ---------------------------------------------------------------------------
interface imem_responder_if;

  logic        REQ;
  logic [31:0] ADDR;
  logic        READY;
  logic [31:0] RDATA;
  logic        VALID;
  logic        WE;
  logic [31:0] WADDR;
  logic [31:0] WDATA;
`ifdef IMEM_ADDR_CHECK_EN
  logic        ERR;

  modport master (output REQ, ADDR, WE, WADDR, WDATA,
                  input  READY, RDATA, VALID, ERR);
  modport slave  (input  REQ, ADDR, WE, WADDR, WDATA,
                  output READY, RDATA, VALID, ERR);
`else
  modport master (output REQ, ADDR, WE, WADDR, WDATA,
                  input  READY, RDATA, VALID);
  modport slave  (input  REQ, ADDR, WE, WADDR, WDATA,
                  output READY, RDATA, VALID);
`endif

endinterface

// File: rtl/imem_array.sv
// ---------------------------------------------------------------------------
// imem_array
// Word storage for the instruction memory. Contents are never reset.
//   CLK    write clock (rising edge)
//   we     write enable; waddr/wdata written on the rising edge
//   raddr  read word index; rdata is a combinational read, so a write and a
//          registered read on the same edge see the pre-write contents
// ---------------------------------------------------------------------------
module imem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [DEPTH_WORDS];

  // Synchronous preload write port
  always_ff @(posedge CLK) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
// Instruction-memory responder for a fetch stage. A request accepted on
// REQ && READY is answered WAIT_CYCLES cycles later with a single-cycle VALID;
// a request accepted while responding is serviced back-to-back.
//   CLK    clock, rising edge
//   RSTn   asynchronous active-low reset
//   bus    imem_responder_if.slave (REQ/ADDR/READY/RDATA/VALID, WE/WADDR/WDATA,
//          ERR only when IMEM_ADDR_CHECK_EN is defined)
// Optional feature macro: IMEM_ADDR_CHECK_EN -- misaligned or out-of-range
// addresses respond with NOP_INSTR and ERR=1 instead of wrapping.
// ---------------------------------------------------------------------------
module imem_responder
  import imem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RSTn,
  imem_responder_if.slave  bus
);

  localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t        state_r;
  logic [3:0]    cnt_r;
  logic [31:0]   addr_r;
  logic          ready_r;
  logic          valid_r;
  logic [31:0]   rdata_r;

  logic [31:0]   rd_byte_addr_s;
  logic [AW-1:0] rd_idx_s;
  logic [AW-1:0] wr_idx_s;
  logic [31:0]   mem_data_s;
  logic [31:0]   resp_data_s;

  // Address feeding the read port: the latched address while waiting, else the
  // live request address (used when WAIT_CYCLES=0 loads RDATA on acceptance)
  always_comb begin
    if (state_r == WAIT) begin
      rd_byte_addr_s = addr_r;
    end else begin
      rd_byte_addr_s = bus.ADDR;
    end
    rd_idx_s = AW'(word_offset(rd_byte_addr_s, BASE_ADDR));
    wr_idx_s = AW'(word_offset(bus.WADDR, BASE_ADDR));
  end

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .CLK   (CLK),
    .we    (bus.WE),
    .waddr (wr_idx_s),
    .wdata (bus.WDATA),
    .raddr (rd_idx_s),
    .rdata (mem_data_s)
  );

`ifdef IMEM_ADDR_CHECK_EN
  localparam logic [32:0] ADDR_SPAN = 33'(DEPTH_WORDS) * 33'd4;

  logic [31:0] chk_off_s;
  logic        err_s;
  logic        load_s;
  logic        err_r;

  // Fault detection on the address being loaded; the unsigned offset also
  // catches addresses below BASE_ADDR
  always_comb begin
    chk_off_s = rd_byte_addr_s - BASE_ADDR;
    err_s     = (rd_byte_addr_s[1:0] != 2'b00) || ({1'b0, chk_off_s} >= ADDR_SPAN);
    if (state_r == WAIT) begin
      load_s = (cnt_r <= 4'd1);
    end else begin
      load_s = bus.REQ && ready_r && (WAIT_LOAD == 4'd0);
    end
    if (err_s) begin
      resp_data_s = NOP_INSTR;
    end else begin
      resp_data_s = mem_data_s;
    end
  end

  // Fault flag, high only in the VALID cycle of a faulting response
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      err_r <= 1'b0;
    end else if (load_s) begin
      err_r <= err_s;
    end else begin
      err_r <= 1'b0;
    end
  end

  assign bus.ERR = err_r;
`else
  // Response data straight from the array; addresses wrap modulo depth
  always_comb begin
    resp_data_s = mem_data_s;
  end
`endif

  // Responder FSM with registered READY/VALID/RDATA
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= 32'h0000_0000;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      rdata_r <= NOP_INSTR;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        IDLE, RESP: begin
          // READY is high in both states, so REQ alone means acceptance
          if (bus.REQ) begin
            addr_r <= bus.ADDR;
            if (WAIT_LOAD != 4'd0) begin
              state_r <= WAIT;
              cnt_r   <= WAIT_LOAD;
              ready_r <= 1'b0;
            end else begin
              state_r <= RESP;
              cnt_r   <= 4'd0;
              ready_r <= 1'b1;
              valid_r <= 1'b1;
              rdata_r <= resp_data_s;
            end
          end else begin
            state_r <= IDLE;
            ready_r <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_r <= 4'd1) begin
            state_r <= RESP;
            cnt_r   <= 4'd0;
            ready_r <= 1'b1;
            valid_r <= 1'b1;
            rdata_r <= resp_data_s;
          end else begin
            cnt_r   <= cnt_r - 4'd1;
            ready_r <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 4'd0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.READY = ready_r;
  assign bus.VALID = valid_r;
  assign bus.RDATA = rdata_r;

endmodule

// File: tb/tb_imem_responder.sv
// ---------------------------------------------------------------------------
// tb_imem_responder
// Two responders side by side: dut_a (BASE 0, 2 wait states) and dut_b
// (BASE 0x1000, no wait states), both 16 words deep. A reference model keeps
// the memory image plus the edge index of the last accepted request and
// derives READY/VALID/RDATA/ERR from edge arithmetic. Directed steps are
// followed by randomized traffic. Build with IMEM_ADDR_CHECK_EN to cover ERR.
// ---------------------------------------------------------------------------
module tb_imem_responder;
  import imem_pkg::*;

  localparam int          DEPTH  = 16;
  localparam int          WC_A   = 2;
  localparam int          WC_B   = 0;
  localparam logic [31:0] BASE_A = 32'h0000_0000;
  localparam logic [31:0] BASE_B = 32'h0000_1000;

  logic CLK = 1'b0;
  logic RSTn;

  always #5 CLK = ~CLK;

  imem_responder_if ifa ();
  imem_responder_if ifb ();

  imem_responder #(.BASE_ADDR(BASE_A), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC_A))
    dut_a (.CLK(CLK), .RSTn(RSTn), .bus(ifa));
  imem_responder #(.BASE_ADDR(BASE_B), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC_B))
    dut_b (.CLK(CLK), .RSTn(RSTn), .bus(ifb));

  // reference model state
  int          wc_m      [2];
  logic [31:0] base_m    [2];
  logic [31:0] mem_m     [2][DEPTH];
  bit          has_acc   [2];
  int          last_acc  [2];
  logic [31:0] lat_addr  [2];
  bit          acc_now   [2];
  logic [31:0] exp_rdata [2];
  logic        exp_valid [2];
  logic        exp_err   [2];
  logic        exp_ready [2];
  int          edge_n;
  int          n_vec;
  int          n_mis;

  function automatic int widx(input int d, input logic [31:0] a);
    logic [31:0] off;
    off = (a - base_m[d]) >> 2;
    return int'(off % 32'(DEPTH));
  endfunction

  function automatic bit bad_addr(input int d, input logic [31:0] a);
    logic [31:0] off;
    off = a - base_m[d];
    return (a[1:0] != 2'b00) || (off >= 32'(4 * DEPTH));
  endfunction

  task automatic model_reset(input int d);
    has_acc[d]   = 1'b0;
    exp_rdata[d] = NOP_INSTR;
    exp_valid[d] = 1'b0;
    exp_err[d]   = 1'b0;
    exp_ready[d] = 1'b1;
  endtask

  // One rising edge of the model, from the inputs present at that edge.
  task automatic model_edge(input int d, input logic req, input logic [31:0] addr,
                            input logic we, input logic [31:0] waddr,
                            input logic [31:0] wdata);
    bit rdy;
    rdy        = !has_acc[d] || (edge_n > last_acc[d] + wc_m[d]);
    acc_now[d] = 1'b0;
    if (!RSTn) begin
      model_reset(d);
    end else begin
      exp_valid[d] = 1'b0;
      exp_err[d]   = 1'b0;
      if (req && rdy) begin
        has_acc[d]  = 1'b1;
        last_acc[d] = edge_n;
        lat_addr[d] = addr;
        acc_now[d]  = 1'b1;
      end
      if (has_acc[d] && (edge_n == last_acc[d] + wc_m[d])) begin
        exp_valid[d] = 1'b1;
`ifdef IMEM_ADDR_CHECK_EN
        if (bad_addr(d, lat_addr[d])) begin
          exp_rdata[d] = NOP_INSTR;
          exp_err[d]   = 1'b1;
        end else begin
          exp_rdata[d] = mem_m[d][widx(d, lat_addr[d])];
        end
`else
        exp_rdata[d] = mem_m[d][widx(d, lat_addr[d])];
`endif
      end
      exp_ready[d] = !has_acc[d] || (edge_n + 1 > last_acc[d] + wc_m[d]);
    end
    if (we) mem_m[d][widx(d, waddr)] = wdata;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_valid", 32'(ifa.VALID), 32'(exp_valid[0]));
    chk("a_ready", 32'(ifa.READY), 32'(exp_ready[0]));
    chk("a_rdata", ifa.RDATA, exp_rdata[0]);
    chk("b_valid", 32'(ifb.VALID), 32'(exp_valid[1]));
    chk("b_ready", 32'(ifb.READY), 32'(exp_ready[1]));
    chk("b_rdata", ifb.RDATA, exp_rdata[1]);
`ifdef IMEM_ADDR_CHECK_EN
    chk("a_err", 32'(ifa.ERR), 32'(exp_err[0]));
    chk("b_err", 32'(ifb.ERR), 32'(exp_err[1]));
`endif
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge(0, ifa.REQ, ifa.ADDR, ifa.WE, ifa.WADDR, ifa.WDATA);
    model_edge(1, ifb.REQ, ifb.ADDR, ifb.WE, ifb.WADDR, ifb.WDATA);
    edge_n++;
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    ifa.REQ = 1'b0; ifa.ADDR = BASE_A; ifa.WE = 1'b0; ifa.WADDR = BASE_A; ifa.WDATA = 32'h0;
    ifb.REQ = 1'b0; ifb.ADDR = BASE_B; ifb.WE = 1'b0; ifb.WADDR = BASE_B; ifb.WDATA = 32'h0;
  endtask

  initial begin
    logic [31:0] old_w;
    int          na;
    wc_m[0] = WC_A;    wc_m[1] = WC_B;
    base_m[0] = BASE_A; base_m[1] = BASE_B;
    n_vec = 0; n_mis = 0; edge_n = 0;
    for (int d = 0; d < 2; d++) begin
      model_reset(d);
      last_acc[d] = 0;
      lat_addr[d] = 32'h0;
      for (int w = 0; w < DEPTH; w++) mem_m[d][w] = 32'h0;
    end
    idle_inputs();
    RSTn = 1'b0;

    // reset state
    repeat (3) step();
    chk("reset_rdata", ifa.RDATA, NOP_INSTR);
    chk("reset_valid", 32'(ifa.VALID), 32'h0);
    chk("reset_ready", 32'(ifa.READY), 32'h1);
    #2 RSTn = 1'b1;

    // preload every word of both memories
    for (int i = 0; i < DEPTH; i++) begin
      ifa.WE = 1'b1; ifa.WADDR = BASE_A + 32'(4 * i);
      ifa.WDATA = (i == 0) ? 32'h0010_0093 : $urandom();
      ifb.WE = 1'b1; ifb.WADDR = BASE_B + 32'(4 * i);
      ifb.WDATA = $urandom();
      step();
    end
    idle_inputs();
    step();

    // single request, two wait states: VALID only on the third cycle
    ifa.REQ = 1'b1; ifa.ADDR = 32'h0;
    step();
    ifa.REQ = 1'b0;
    step();
    chk("r034_early", 32'(ifa.VALID), 32'h0);
    step();
    chk("r034_valid", 32'(ifa.VALID), 32'h1);
    chk("r034_rdata", ifa.RDATA, 32'h0010_0093);
    step();
    chk("r034_once", 32'(ifa.VALID), 32'h0);

    // REQ held high: a serves 0,4,8 three cycles apart, b streams
    na = 0;
    ifa.REQ = 1'b1; ifa.ADDR = 32'h0;
    ifb.REQ = 1'b1; ifb.ADDR = BASE_B;
    for (int k = 0; k < 12; k++) begin
      step();
      if (acc_now[0]) begin
        na++;
        ifa.ADDR = 32'(4 * na);
        if (na == 3) ifa.REQ = 1'b0;
      end
      if (acc_now[1]) ifb.ADDR = ifb.ADDR + 32'd4;
      if (k == 5) ifb.REQ = 1'b0;
    end
    repeat (3) step();

    // address beyond the array, then a misaligned one
    ifa.REQ = 1'b1; ifa.ADDR = 32'(4 * DEPTH);
    step();
    ifa.REQ = 1'b0;
    repeat (2) step();
`ifdef IMEM_ADDR_CHECK_EN
    chk("range_err", 32'(ifa.ERR), 32'h1);
    chk("range_nop", ifa.RDATA, NOP_INSTR);
`else
    chk("wrap_word0", ifa.RDATA, 32'h0010_0093);
`endif
    ifa.REQ = 1'b1; ifa.ADDR = 32'h0000_0002;
    step();
    ifa.REQ = 1'b0;
    repeat (2) step();
`ifdef IMEM_ADDR_CHECK_EN
    chk("misal_err", 32'(ifa.ERR), 32'h1);
    chk("misal_nop", ifa.RDATA, NOP_INSTR);
`endif
    step();

    // write to word1 on the edge it is read (b: zero wait states)
    old_w = mem_m[1][1];
    ifb.REQ = 1'b1; ifb.ADDR = BASE_B + 32'd4;
    ifb.WE = 1'b1;  ifb.WADDR = BASE_B + 32'd4; ifb.WDATA = 32'hDEAD_BEEF;
    step();
    chk("wr_same_old", ifb.RDATA, old_w);
    ifb.WE = 1'b0;
    step();
    chk("wr_same_new", ifb.RDATA, 32'hDEAD_BEEF);
    ifb.REQ = 1'b0;
    step();

    // same on a, write landing on the edge that loads RDATA
    old_w = mem_m[0][1];
    ifa.REQ = 1'b1; ifa.ADDR = 32'h4;
    step();
    ifa.REQ = 1'b0;
    step();
    ifa.WE = 1'b1; ifa.WADDR = 32'h4; ifa.WDATA = 32'hDEAD_BEEF;
    step();
    chk("a_wr_same_old", ifa.RDATA, old_w);
    ifa.WE = 1'b0;
    ifa.REQ = 1'b1;
    step();
    ifa.REQ = 1'b0;
    repeat (2) step();
    chk("a_wr_same_new", ifa.RDATA, 32'hDEAD_BEEF);
    step();

    // reset while a is waiting: no VALID, NOP, then a fresh request works
    ifa.REQ = 1'b1; ifa.ADDR = 32'h8;
    step();
    ifa.REQ = 1'b0;
    #2 RSTn = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    chk("rst_wait_valid", 32'(ifa.VALID), 32'h0);
    chk("rst_wait_rdata", ifa.RDATA, NOP_INSTR);
    chk("rst_wait_ready", 32'(ifa.READY), 32'h1);
    repeat (2) step();
    #2 RSTn = 1'b1;
    repeat (3) step();
    ifa.REQ = 1'b1; ifa.ADDR = 32'h8;
    step();
    ifa.REQ = 1'b0;
    repeat (2) step();
    chk("rst_fresh_valid", 32'(ifa.VALID), 32'h1);
    chk("rst_fresh_rdata", ifa.RDATA, mem_m[0][2]);
    step();

    // randomized traffic: requests, occasional wrap/misaligned, preload writes
    for (int i = 0; i < 400; i++) begin
      ifa.REQ   = 1'($urandom_range(0, 1));
      ifa.ADDR  = BASE_A + 32'(4 * $urandom_range(0, 19))
                + (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
      ifa.WE    = ($urandom_range(0, 3) == 0);
      ifa.WADDR = BASE_A + 32'(4 * $urandom_range(0, DEPTH - 1));
      ifa.WDATA = $urandom();
      ifb.REQ   = 1'($urandom_range(0, 1));
      ifb.ADDR  = BASE_B + 32'(4 * $urandom_range(0, 19))
                + (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
      ifb.WE    = ($urandom_range(0, 3) == 0);
      ifb.WADDR = BASE_B + 32'(4 * $urandom_range(0, DEPTH - 1));
      ifb.WDATA = $urandom();
      step();
    end
    idle_inputs();
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
